uart_cfg: RTL
=============

// Module: uart_cfg
// PURPOSE
//   Runtime-configurable UART: AXI-Stream TX/RX with per-frame data bits (5-8), parity (none/even/odd),
//   stop bits (1/2), runtime baud divisor, and RX error reporting (parity, framing, break, overrun).
//   Parametrised successor to the fixed 8N1 uart; drops in where software must set line format at run time.
//   TX and RX each own a synchronous FIFO between the stream port and the bit engine.
// PARAMETERS
//   TX_FIFO_DEPTH   32    TX FIFO entries, power of 2, >=2
//   RX_FIFO_DEPTH   32    RX FIFO entries, power of 2, >=2
//   DIV_WIDTH       16    width of baud divisor input
//   DEFAULT_DIV     868   divisor used while cfg_div==0 (115200 bps @ 100 MHz)
// PORTS
//   clk            in   1          system clock
//   reset_n        in   1          asynchronous active-low reset
//   cfg_div        in   DIV_WIDTH  clocks per bit; 0 -> DEFAULT_DIV; 1..3 -> treated as 4
//   cfg_data_bits  in   2          0:5 1:6 2:7 3:8 data bits
//   cfg_parity     in   2          0:none 1:even 2:odd 3:none
//   cfg_stop2      in   1          1: two stop bits on TX (RX always checks first stop only)
//   s_axis_tdata   in   8          TX byte; bits above data width ignored
//   s_axis_tvalid  in   1          TX valid
//   s_axis_tready  out  1          TX ready = !tx_fifo_full
//   m_axis_tdata   out  8          RX byte, zero-extended above data width
//   m_axis_tuser   out  4          {break, overrun, framing_err, parity_err} for this word
//   m_axis_tvalid  out  1          RX valid = !rx_fifo_empty
//   m_axis_tready  in   1          RX ready
//   rxd            in   1          asynchronous serial input
//   txd            out  1          serial output, idle high
//   tx_busy        out  1          TX FIFO non-empty or TX frame in progress
// BEHAVIOUR
//   Reset (async, any time incl. mid-frame): txd=1, s_axis_tready=1 after release, m_axis_tvalid=0,
//     m_axis_tdata/tuser=0, tx_busy=0; both FIFOs emptied, FSMs to IDLE, rxd synchroniser flops =1.
//   Config sampled into shadow regs at frame start (TX: leaving IDLE; RX: start edge); mid-frame cfg changes
//     affect only the next frame.
//   Stream handshakes: transfer on tvalid&&tready; FIFOs register-read, no combinational valid->ready path.
//     Write to full FIFO never occurs (tready low); simultaneous push+pop legal at any non-full/non-empty level.
//   TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE; each state lasts exactly div clks.
//     Data LSB first, N bits; parity even: XOR of data bits, odd: inverted. Byte accepted with TX idle and FIFO
//     empty -> txd falls exactly 2 clks after the handshake. Back-to-back frames: next START immediately
//     follows last stop bit, no idle gap.
//   RX: rxd through 2-flop synchroniser. FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE (or BREAK).
//     IDLE: falling edge of synchronised rxd starts counter; at div/2 (floor) re-sample: high -> false start,
//     back to IDLE, nothing written. Subsequent samples every div clks (mid-bit).
//     parity_err: received parity mismatches computed; framing_err: stop sample ==0.
//     break: all data bits, parity (if on) and stop ==0; word written with data 0, break=1, framing_err=1;
//     FSM then waits in BREAK until rxd high before IDLE.
//     Word written to RX FIFO on the stop-bit sample cycle. If RX FIFO full then: word dropped, sticky overrun
//     flag set; flag is attached (tuser[2]) to the next word successfully written, then cleared.
//   Counters: bit counter 3 bits, baud counter DIV_WIDTH bits, wrap to 0 on reaching div-1.
// TESTING
//   div=8, 8N1, send 0xA5 -> txd: start at handshake+2, then 1,0,1,0,0,1,0,1, stop; each bit 8 clks; tx_busy
//     high until stop ends.
//   txd looped to rxd, div=16, 7E2, send 0x00,0x7F,0x55 back-to-back -> RX words 0x00,0x7F,0x55, tuser=0,
//     no idle gap between TX frames.
//   8O1 frame on rxd with flipped parity bit, then valid frame 0x3C -> word1 tuser=4'b0001, word2 0x3C/0000.
//   rxd low for 12 bit times (8N1), then high -> one word data 0x00 tuser=4'b1010; no further words.
//   RX_FIFO_DEPTH=4, m_axis_tready=0, 6 frames in -> 4 words held; drop frame 5,6; release ready, frame 7
//     -> first 4 words clean, 5th word = frame 7 with tuser[2]=1.
//   Assert reset_n low mid-DATA of TX and RX frame -> txd=1 same cycle, tvalid=0, FIFOs empty; after release,
//     fresh frame 0x81 round-trips correctly; glitch low < div/2 on rxd -> no word.

Source files
------------

// File: rtl/uart_cfg.sv
// Runtime-configurable UART: AXI-Stream TX/RX through synchronous FIFOs, with
// the line format (5-8 data bits, parity, 1/2 stop bits, divisor) latched per frame.

module uart_cfg_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             rd_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      cnt_q;
   logic             wr_en, rd_en;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign wr_en   = wr_i && !full_o;
   assign rd_en   = rd_i && !empty_o;
   // An empty FIFO presents zero so the stream outputs are clean after reset.
   assign dout_o  = empty_o ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + 1'b1;
         if (rd_en) rptr_q <= rptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= din_i;
   end
endmodule

module uart_cfg #(
   parameter int TX_FIFO_DEPTH = 32,
   parameter int RX_FIFO_DEPTH = 32,
   parameter int DIV_WIDTH     = 16,
   parameter int DEFAULT_DIV   = 868
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   input  logic [1:0]           cfg_data_bits,
   input  logic [1:0]           cfg_parity,
   input  logic                 cfg_stop2,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [7:0]           m_axis_tdata,
   output logic [3:0]           m_axis_tuser,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   input  logic                 rxd,
   output logic                 txd,
   output logic                 tx_busy
);
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_t;

   function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] d);
      if (d == '0)                 return DIV_WIDTH'(DEFAULT_DIV);
      else if (d < DIV_WIDTH'(4))  return DIV_WIDTH'(4);
      else                         return d;
   endfunction

   // Live configuration decode; copied into shadow registers at frame start.
   logic [DIV_WIDTH-1:0] cfg_div_eff;
   logic [2:0]           cfg_nb;
   logic [7:0]           cfg_mask;
   logic                 cfg_pen, cfg_podd;

   assign cfg_div_eff = eff_div(cfg_div);
   assign cfg_nb      = 3'd4 + {1'b0, cfg_data_bits};
   assign cfg_mask    = 8'hFF >> (2'd3 - cfg_data_bits);
   assign cfg_pen     = (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
   assign cfg_podd    = (cfg_parity == 2'd2);

   // ---------------- TX ----------------
   logic [7:0] tx_dout;
   logic       tx_empty, tx_full, tx_pop, tx_tick;

   uart_cfg_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset_n(reset_n),
      .wr_i(s_axis_tvalid), .din_i(s_axis_tdata),
      .rd_i(tx_pop), .dout_o(tx_dout),
      .empty_o(tx_empty), .full_o(tx_full)
   );

   tx_state_t            tx_state_q, tx_state_d;
   logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]           tx_bit_q, tx_bit_d, tx_nb_q, tx_nb_d;
   logic [7:0]           tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_stop2_q, tx_stop2_d;
   logic                 txd_q, txd_d, tx_busy_q, tx_busy_d;

   assign s_axis_tready = !tx_full;
   assign tx_tick       = (tx_cnt_q == tx_div_q - 1'b1);
   assign txd           = txd_q;
   // busy_q covers the extra cycle the registered txd lags the FSM.
   assign tx_busy       = !tx_empty || (tx_state_q != TX_IDLE) || tx_busy_q;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      tx_div_d   = tx_div_q;
      tx_nb_d    = tx_nb_q;
      tx_pen_d   = tx_pen_q;
      tx_stop2_d = tx_stop2_q;
      tx_pop     = 1'b0;
      tx_busy_d  = (tx_state_q != TX_IDLE);
      txd_d      = 1'b1;
      case (tx_state_q)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = tx_sh_q[0];
         TX_PAR:   txd_d = tx_par_q;
         default:  txd_d = 1'b1;
      endcase
      if (tx_state_q != TX_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
      case (tx_state_q)
         TX_IDLE:  tx_pop = !tx_empty;
         TX_START: if (tx_tick) begin
            tx_state_d = TX_DATA;
            tx_bit_d   = '0;
         end
         TX_DATA:  if (tx_tick) begin
            tx_sh_d = {1'b0, tx_sh_q[7:1]};
            if (tx_bit_q == tx_nb_q) tx_state_d = tx_pen_q ? TX_PAR : TX_STOP1;
            else                     tx_bit_d   = tx_bit_q + 1'b1;
         end
         TX_PAR:   if (tx_tick) tx_state_d = TX_STOP1;
         TX_STOP1: if (tx_tick) begin
            if (tx_stop2_q) tx_state_d = TX_STOP2;
            else begin
               tx_pop     = !tx_empty;
               tx_state_d = TX_IDLE;
            end
         end
         TX_STOP2: if (tx_tick) begin
            tx_pop     = !tx_empty;
            tx_state_d = TX_IDLE;
         end
         default:  tx_state_d = TX_IDLE;
      endcase
      // Popping from the last stop bit chains frames with no idle gap.
      if (tx_pop) begin
         tx_state_d = TX_START;
         tx_cnt_d   = '0;
         tx_sh_d    = tx_dout & cfg_mask;
         tx_par_d   = (^(tx_dout & cfg_mask)) ^ cfg_podd;
         tx_div_d   = cfg_div_eff;
         tx_nb_d    = cfg_nb;
         tx_pen_d   = cfg_pen;
         tx_stop2_d = cfg_stop2;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_div_q   <= DIV_WIDTH'(4);
         tx_nb_q    <= 3'd7;
         tx_pen_q   <= 1'b0;
         tx_stop2_q <= 1'b0;
         txd_q      <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         tx_div_q   <= tx_div_d;
         tx_nb_q    <= tx_nb_d;
         tx_pen_q   <= tx_pen_d;
         tx_stop2_q <= tx_stop2_d;
         txd_q      <= txd_d;
         tx_busy_q  <= tx_busy_d;
      end
   end

   // ---------------- RX ----------------
   logic [11:0] rx_word, rx_dout;
   logic        rx_push, rx_empty, rx_full, rx_tick, rx_half, rx_brk;

   uart_cfg_fifo #(.WIDTH(12), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset_n(reset_n),
      .wr_i(rx_push), .din_i(rx_word),
      .rd_i(m_axis_tready), .dout_o(rx_dout),
      .empty_o(rx_empty), .full_o(rx_full)
   );

   assign m_axis_tvalid = !rx_empty;
   assign m_axis_tdata  = rx_dout[7:0];
   assign m_axis_tuser  = rx_dout[11:8];

   rx_state_t            rx_state_q, rx_state_d;
   logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [2:0]           rx_bit_q, rx_bit_d, rx_nb_q, rx_nb_d;
   logic [7:0]           rx_data_q, rx_data_d;
   logic                 rx_pacc_q, rx_pacc_d, rx_zero_q, rx_zero_d, rx_perr_q, rx_perr_d;
   logic                 rx_pen_q, rx_pen_d, rx_podd_q, rx_podd_d, rx_ovr_q, rx_ovr_d;
   logic                 rx_s1_q, rx_s2_q, rx_prev_q;

   assign rx_tick = (rx_cnt_q == rx_div_q - 1'b1);
   assign rx_half = (rx_cnt_q == (rx_div_q >> 1));
   assign rx_brk  = rx_zero_q && !rx_s2_q;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_div_d   = rx_div_q;
      rx_bit_d   = rx_bit_q;
      rx_nb_d    = rx_nb_q;
      rx_data_d  = rx_data_q;
      rx_pacc_d  = rx_pacc_q;
      rx_zero_d  = rx_zero_q;
      rx_perr_d  = rx_perr_q;
      rx_pen_d   = rx_pen_q;
      rx_podd_d  = rx_podd_q;
      rx_ovr_d   = rx_ovr_q;
      rx_push    = 1'b0;
      rx_word    = {4'b0000, rx_data_q};
      if (rx_state_q inside {RX_DATA, RX_PAR, RX_STOP})
         rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
      case (rx_state_q)
         RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
            rx_state_d = RX_START;
            rx_cnt_d   = '0;
            rx_div_d   = cfg_div_eff;
            rx_nb_d    = cfg_nb;
            rx_pen_d   = cfg_pen;
            rx_podd_d  = cfg_podd;
         end
         RX_START: begin
            rx_cnt_d = rx_cnt_q + 1'b1;
            if (rx_half) begin
               if (rx_s2_q) rx_state_d = RX_IDLE;
               else begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = '0;
                  rx_bit_d   = '0;
                  rx_data_d  = '0;
                  rx_pacc_d  = 1'b0;
                  rx_zero_d  = 1'b1;
                  rx_perr_d  = 1'b0;
               end
            end
         end
         RX_DATA: if (rx_tick) begin
            rx_data_d[rx_bit_q] = rx_s2_q;
            rx_pacc_d = rx_pacc_q ^ rx_s2_q;
            rx_zero_d = rx_zero_q & !rx_s2_q;
            if (rx_bit_q == rx_nb_q) rx_state_d = rx_pen_q ? RX_PAR : RX_STOP;
            else                     rx_bit_d   = rx_bit_q + 1'b1;
         end
         RX_PAR: if (rx_tick) begin
            rx_perr_d  = rx_s2_q ^ rx_pacc_q ^ rx_podd_q;
            rx_zero_d  = rx_zero_q & !rx_s2_q;
            rx_state_d = RX_STOP;
         end
         RX_STOP: if (rx_tick) begin
            rx_word = {rx_brk, rx_ovr_q, !rx_s2_q, rx_perr_q & !rx_brk,
                       rx_brk ? 8'h00 : rx_data_q};
            // A full FIFO drops the word; the loss is reported on the next stored word.
            if (rx_full) rx_ovr_d = 1'b1;
            else begin
               rx_push  = 1'b1;
               rx_ovr_d = 1'b0;
            end
            rx_state_d = rx_brk ? RX_BREAK : RX_IDLE;
         end
         RX_BREAK: if (rx_s2_q) rx_state_d = RX_IDLE;
         default:  rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_div_q   <= DIV_WIDTH'(4);
         rx_bit_q   <= '0;
         rx_nb_q    <= 3'd7;
         rx_data_q  <= '0;
         rx_pacc_q  <= 1'b0;
         rx_zero_q  <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_pen_q   <= 1'b0;
         rx_podd_q  <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         rx_s1_q    <= rxd;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         rx_bit_q   <= rx_bit_d;
         rx_nb_q    <= rx_nb_d;
         rx_data_q  <= rx_data_d;
         rx_pacc_q  <= rx_pacc_d;
         rx_zero_q  <= rx_zero_d;
         rx_perr_q  <= rx_perr_d;
         rx_pen_q   <= rx_pen_d;
         rx_podd_q  <= rx_podd_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end
endmodule
